// File: rtl/spi_target_bridge_pkg.sv
// Shared frame constants and state encoding for the SPI register-bridge protocol.
// Frame layout, bit 23 first: R/W | W1W0[1:0] | address[12:0] | data[7:0].
// The SPI controller on the other end of the link reuses these definitions.
package spi_target_bridge_pkg;

  localparam int unsigned FRAME_BITS = 24;
  localparam int unsigned INSTR_BITS = 16;
  localparam int unsigned ADDR_W     = 13;
  localparam int unsigned DATA_W     = 8;

  // Bit positions within the full 24-bit frame.
  localparam int unsigned RW_BIT     = 23;
  localparam int unsigned W1W0_MSB   = 22;
  localparam int unsigned W1W0_LSB   = 21;

  // The same fields indexed within the 16-bit instruction word.
  localparam int unsigned INSTR_RW   = RW_BIT - DATA_W;
  localparam int unsigned INSTR_W1W0 = W1W0_MSB - DATA_W;

  typedef enum logic [1:0] {
    StIdle,
    StCmd,
    StData,
    StDone
  } state_e;

  // Only single-byte transfers (W1W0 = 00) are supported.
  function automatic logic instr_is_single(input logic [INSTR_BITS-1:0] instr);
    return instr[INSTR_W1W0 -: 2] == 2'b00;
  endfunction

endpackage

// File: rtl/spi_target_bridge_if.sv
// Bundles the SPI pins, register bus and status flags of spi_target_bridge.
//   master : bridge side (drives MISO, register strobes, address/data, status)
//   slave  : environment side (drives SCLK/CS_N/MOSI and register read data)
interface spi_target_bridge_if;
  import spi_target_bridge_pkg::*;

  logic              spi_sclk;
  logic              spi_cs_n;
  logic              spi_mosi;
  logic              spi_miso;
  logic              spi_miso_oe;
  logic              reg_wr_en;
  logic              reg_rd_en;
  logic [ADDR_W-1:0] reg_addr;
  logic [DATA_W-1:0] reg_wdata;
  logic [DATA_W-1:0] reg_rdata;
  logic              busy;
  logic              frame_err;
  logic              overrun;

  modport master (
    input  spi_sclk, spi_cs_n, spi_mosi, reg_rdata,
    output spi_miso, spi_miso_oe, reg_wr_en, reg_rd_en, reg_addr, reg_wdata,
           busy, frame_err, overrun
  );

  modport slave (
    output spi_sclk, spi_cs_n, spi_mosi, reg_rdata,
    input  spi_miso, spi_miso_oe, reg_wr_en, reg_rd_en, reg_addr, reg_wdata,
           busy, frame_err, overrun
  );

endinterface

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for one asynchronous input, plus one extra flop for
// edge detection.
//   clk_i, rst_i : system clock, async active-high reset
//   async_i      : asynchronous input
//   sync_o       : synchronized level
//   rise_o/fall_o: one-clk pulses on synchronized rising/falling edges
module spi_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        RESET_VAL   = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic async_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign sync_o = sync_q[SYNC_STAGES-1];
  assign rise_o = sync_o & ~prev_q;
  assign fall_o = ~sync_o & prev_q;

endmodule

// File: rtl/spi_target_bridge.sv
// SPI target (mode 0, MSB first, 24-bit frames) decoding a 16-bit instruction
// plus one data byte into register write strobes and read requests.
//   clk, rst : system clock (>= 16x SCLK), async active-high reset
//   bus      : SPI pins, register bus and status flags (master view)
module spi_target_bridge
  import spi_target_bridge_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst,
  spi_target_bridge_if.master bus
);

  logic sclk_sync, sclk_rise, sclk_fall;
  logic cs_sync, cs_rise, cs_fall;
  logic mosi_sync, mosi_rise, mosi_fall;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk_i  (clk),
    .rst_i  (rst),
    .async_i(bus.spi_sclk),
    .sync_o (sclk_sync),
    .rise_o (sclk_rise),
    .fall_o (sclk_fall)
  );

  // CS_N idles high; resetting its chain high avoids a false edge after reset.
  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
    .clk_i  (clk),
    .rst_i  (rst),
    .async_i(bus.spi_cs_n),
    .sync_o (cs_sync),
    .rise_o (cs_rise),
    .fall_o (cs_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk_i  (clk),
    .rst_i  (rst),
    .async_i(bus.spi_mosi),
    .sync_o (mosi_sync),
    .rise_o (mosi_rise),
    .fall_o (mosi_fall)
  );

  logic unused_sync;
  assign unused_sync = ^{sclk_sync, cs_sync, mosi_rise, mosi_fall};

  state_e                  state_q;
  logic [4:0]              cnt_q;
  logic [INSTR_BITS-2:0]   rx_q;     // previous 15 bits; current bit is mosi_sync
  logic [DATA_W-2:0]       tx_q;     // read bits still to be shifted out
  logic                    rw_q;
  logic                    w1w0_bad_q;
  logic                    cap_q;    // reg_rdata valid this clk
  logic                    miso_q;
  logic                    oe_q;
  logic                    wr_en_q;
  logic                    rd_en_q;
  logic [ADDR_W-1:0]       addr_q;
  logic [DATA_W-1:0]       wdata_q;
  logic                    ferr_q;
  logic                    ovr_q;

  logic [INSTR_BITS-1:0]   instr_w;
  logic [DATA_W-1:0]       data_w;

  // Field views including the bit being sampled on this SCLK rise.
  assign instr_w = {rx_q, mosi_sync};
  assign data_w  = {rx_q[DATA_W-2:0], mosi_sync};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      rx_q       <= '0;
      tx_q       <= '0;
      rw_q       <= 1'b0;
      w1w0_bad_q <= 1'b0;
      cap_q      <= 1'b0;
      miso_q     <= 1'b0;
      oe_q       <= 1'b0;
      wr_en_q    <= 1'b0;
      rd_en_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      ferr_q     <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      wr_en_q <= 1'b0;
      rd_en_q <= 1'b0;
      ferr_q  <= 1'b0;
      cap_q   <= rd_en_q;

      // CS_N edges take priority over any SCLK edge seen in the same clk.
      if (cs_rise) begin
        if (state_q != StIdle) begin
          ferr_q <= (cnt_q < 5'(FRAME_BITS)) || w1w0_bad_q;
        end
        state_q <= StIdle;
        oe_q    <= 1'b0;
        miso_q  <= 1'b0;
        cap_q   <= 1'b0;
      end else if (cs_fall) begin
        state_q    <= StCmd;
        cnt_q      <= '0;
        rx_q       <= '0;
        rw_q       <= 1'b0;
        w1w0_bad_q <= 1'b0;
        ovr_q      <= 1'b0;
        oe_q       <= 1'b0;
        miso_q     <= 1'b0;
        cap_q      <= 1'b0;
      end else begin
        if (sclk_rise && (state_q != StIdle)) begin
          rx_q <= {rx_q[INSTR_BITS-3:0], mosi_sync};
          if (cnt_q != 5'(FRAME_BITS)) begin
            cnt_q <= cnt_q + 5'd1;
          end
        end

        unique case (state_q)
          StIdle: begin
          end
          StCmd: begin
            if (sclk_rise && (cnt_q == 5'(INSTR_BITS - 1))) begin
              addr_q     <= instr_w[ADDR_W-1:0];
              rw_q       <= instr_w[INSTR_RW];
              w1w0_bad_q <= !instr_is_single(instr_w);
              rd_en_q    <= instr_w[INSTR_RW] && instr_is_single(instr_w);
              state_q    <= StData;
            end
          end
          StData: begin
            if (cap_q) begin
              tx_q   <= bus.reg_rdata[DATA_W-2:0];
              miso_q <= bus.reg_rdata[DATA_W-1];
              oe_q   <= 1'b1;
            end else if (sclk_fall && oe_q && (cnt_q > 5'(INSTR_BITS))) begin
              // The 16th fall must not shift: bit 7 is sampled on rise 17.
              miso_q <= tx_q[DATA_W-2];
              tx_q   <= {tx_q[DATA_W-3:0], 1'b0};
            end
            if (sclk_rise && (cnt_q == 5'(FRAME_BITS - 1))) begin
              state_q <= StDone;
              if (!rw_q && !w1w0_bad_q) begin
                wdata_q <= data_w;
                wr_en_q <= 1'b1;
              end
            end
          end
          StDone: begin
            if (sclk_rise) begin
              ovr_q <= 1'b1;
            end
          end
        endcase
      end
    end
  end

  assign bus.spi_miso    = miso_q;
  assign bus.spi_miso_oe = oe_q;
  assign bus.reg_wr_en   = wr_en_q;
  assign bus.reg_rd_en   = rd_en_q;
  assign bus.reg_addr    = addr_q;
  assign bus.reg_wdata   = wdata_q;
  assign bus.busy        = (state_q != StIdle);
  assign bus.frame_err   = ferr_q;
  assign bus.overrun     = ovr_q;

endmodule
